// File: rtl/kf8253_bus_master_pkg.sv
// Shared constants and helpers for the 8253 PIT bus master.
// Holds FSM states, op encoding, control-word layout and the per-step transfer decode.
package kf8253_bus_master_pkg;

    // Bus-cycle FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Command op encoding
    localparam logic OP_PROGRAM = 1'b0;
    localparam logic OP_READ    = 1'b1;

    localparam logic [1:0] CTRL_ADDR       = 2'd3;
    localparam logic [1:0] INVALID_COUNTER = 2'd3;

    // Control-word field positions
    localparam int CW_SC_LSB  = 6;
    localparam int CW_RW_LSB  = 4;
    localparam int CW_M_LSB   = 1;
    localparam int CW_BCD_BIT = 0;

    // RW field values
    localparam logic [1:0] RW_LATCH   = 2'b00;
    localparam logic [1:0] RW_LSB_MSB = 2'b11;

    typedef struct packed {
        logic       is_read;
        logic [1:0] addr;
        logic [7:0] wdata;
    } xfer_t;

    function automatic logic [7:0] control_word(
        input logic [1:0] counter,
        input logic [1:0] rw,
        input logic [2:0] mode,
        input logic       bcd
    );
        logic [7:0] cw;
        cw = '0;
        cw[CW_SC_LSB +: 2] = counter;
        cw[CW_RW_LSB +: 2] = rw;
        cw[CW_M_LSB +: 3]  = mode;
        cw[CW_BCD_BIT]     = bcd;
        return cw;
    endfunction

    // Step 0 is always the control/latch write; steps 1-2 move LSB then MSB.
    function automatic xfer_t xfer_word(
        input logic        op,
        input logic [1:0]  counter,
        input logic [2:0]  mode,
        input logic        bcd,
        input logic [15:0] count,
        input logic [1:0]  step
    );
        xfer_t x;
        x.is_read = 1'b0;
        x.addr    = CTRL_ADDR;
        if (op == OP_READ)
            x.wdata = control_word(counter, RW_LATCH, 3'b000, 1'b0);
        else
            x.wdata = control_word(counter, RW_LSB_MSB, mode, bcd);
        case (step)
            2'd1: begin
                x.is_read = (op == OP_READ);
                x.addr    = counter;
                x.wdata   = (op == OP_READ) ? 8'h00 : count[7:0];
            end
            2'd2: begin
                x.is_read = (op == OP_READ);
                x.addr    = counter;
                x.wdata   = (op == OP_READ) ? 8'h00 : count[15:8];
            end
            default: ;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/kf8253_bus_master_if.sv
// Command/response and PIT bus signal bundle for kf8253_bus_master.
// master: the bus master's view; slave: requester plus PIT side.
interface kf8253_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [1:0]  cmd_counter;
    logic [2:0]  cmd_mode;
    logic        cmd_bcd;
    logic [15:0] cmd_count;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        chip_select_n;
    logic        read_enable_n;
    logic        write_enable_n;
    logic [1:0]  address;
    logic [7:0]  data_bus_out;
    logic [7:0]  data_bus_in;

    modport master (
        input  cmd_valid, cmd_op, cmd_counter, cmd_mode, cmd_bcd, cmd_count,
        input  data_bus_in,
        output cmd_ready, rsp_valid, rsp_data,
        output chip_select_n, read_enable_n, write_enable_n, address, data_bus_out
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_counter, cmd_mode, cmd_bcd, cmd_count,
        output data_bus_in,
        input  cmd_ready, rsp_valid, rsp_data,
        input  chip_select_n, read_enable_n, write_enable_n, address, data_bus_out
    );
endinterface

// File: rtl/kf8253_bus_cycle.sv
// One SETUP/STROBE/HOLD access on the PIT bus with registered outputs.
// Ports: start/is_read/addr/wdata in; done (in HOLD), idle, rdata, PIT bus pins out.
module kf8253_bus_cycle
    import kf8253_bus_master_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       is_read,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] data_bus_in,
    output logic       done,
    output logic       idle,
    output logic [7:0] rdata,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic [1:0] address,
    output logic [7:0] data_bus_out
);

    localparam logic [3:0] LAST = 4'(STROBE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       rd_q;

    assign done = (state == ST_HOLD);
    assign idle = (state == ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rd_q           <= 1'b0;
            rdata          <= '0;
            chip_select_n  <= 1'b1;
            read_enable_n  <= 1'b1;
            write_enable_n <= 1'b1;
            address        <= '0;
            data_bus_out   <= '0;
        end else begin
            unique case (state)
                // HOLD may chain straight into the next SETUP
                ST_IDLE, ST_HOLD: begin
                    read_enable_n  <= 1'b1;
                    write_enable_n <= 1'b1;
                    if (start) begin
                        state         <= ST_SETUP;
                        chip_select_n <= 1'b0;
                        address       <= addr;
                        data_bus_out  <= is_read ? 8'h00 : wdata;
                        rd_q          <= is_read;
                    end else begin
                        state         <= ST_IDLE;
                        chip_select_n <= 1'b1;
                        address       <= '0;
                        data_bus_out  <= '0;
                    end
                end
                ST_SETUP: begin
                    state          <= ST_STROBE;
                    cnt            <= '0;
                    read_enable_n  <= !rd_q;
                    write_enable_n <= rd_q;
                end
                ST_STROBE: begin
                    if (cnt == LAST) begin
                        state          <= ST_HOLD;
                        read_enable_n  <= 1'b1;
                        write_enable_n <= 1'b1;
                        if (rd_q)
                            rdata <= data_bus_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/kf8253_bus_master.sv
// Turns program/read commands into three sequenced 8253 bus cycles.
// Ports: clock, reset, bus (cmd_*, rsp_*, PIT chip_select_n/strobes/address/data).
module kf8253_bus_master
    import kf8253_bus_master_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input logic                  clock,
    input logic                  reset,
    kf8253_bus_master_if.master  bus
);

    logic        op_q;
    logic [1:0]  ctr_q;
    logic [2:0]  mode_q;
    logic        bcd_q;
    logic [15:0] count_q;
    logic [1:0]  step_q;
    logic [7:0]  lsb_q;
    logic        inv_busy;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;

    logic        cmd_ready;
    logic        accept;
    logic        start_new;
    logic        advance;
    logic        cyc_done;
    logic        cyc_idle;
    logic [7:0]  cyc_rdata;
    xfer_t       xfer;

    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [1:0]  addr;
    logic [7:0]  dout;

    assign cmd_ready = cyc_idle && !inv_busy;
    assign accept    = bus.cmd_valid && cmd_ready;
    assign start_new = accept && (bus.cmd_counter != INVALID_COUNTER);
    assign advance   = cyc_done && (step_q != 2'd2);

    // A fresh op decodes from the live inputs since capture lands this edge
    always_comb begin
        if (start_new)
            xfer = xfer_word(bus.cmd_op, bus.cmd_counter, bus.cmd_mode,
                             bus.cmd_bcd, bus.cmd_count, 2'd0);
        else
            xfer = xfer_word(op_q, ctr_q, mode_q, bcd_q, count_q,
                             step_q + 2'd1);
    end

    kf8253_bus_cycle #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_cycle (
        .clock          (clock),
        .reset          (reset),
        .start          (start_new || advance),
        .is_read        (xfer.is_read),
        .addr           (xfer.addr),
        .wdata          (xfer.wdata),
        .data_bus_in    (bus.data_bus_in),
        .done           (cyc_done),
        .idle           (cyc_idle),
        .rdata          (cyc_rdata),
        .chip_select_n  (cs_n),
        .read_enable_n  (rd_n),
        .write_enable_n (wr_n),
        .address        (addr),
        .data_bus_out   (dout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q        <= OP_PROGRAM;
            ctr_q       <= '0;
            mode_q      <= '0;
            bcd_q       <= 1'b0;
            count_q     <= '0;
            step_q      <= '0;
            lsb_q       <= '0;
            inv_busy    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            inv_busy    <= 1'b0;
            if (accept) begin
                op_q    <= bus.cmd_op;
                ctr_q   <= bus.cmd_counter;
                mode_q  <= bus.cmd_mode;
                bcd_q   <= bus.cmd_bcd;
                count_q <= bus.cmd_count;
                step_q  <= 2'd0;
                // Counter 3 has no PIT target: one busy clock, no bus traffic
                if (bus.cmd_counter == INVALID_COUNTER) begin
                    inv_busy <= 1'b1;
                    if (bus.cmd_op == OP_READ) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 16'hFFFF;
                    end
                end
            end
            if (advance) begin
                step_q <= step_q + 2'd1;
                if (step_q == 2'd1)
                    lsb_q <= cyc_rdata;
            end
            if (cyc_done && (step_q == 2'd2) && (op_q == OP_READ)) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= {cyc_rdata, lsb_q};
            end
        end
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.chip_select_n  = cs_n;
    assign bus.read_enable_n  = rd_n;
    assign bus.write_enable_n = wr_n;
    assign bus.address        = addr;
    assign bus.data_bus_out   = dout;

endmodule

// File: doc/kf8253_bus_master.md
KF8253_BUS_MASTER -- requirements
Module: kf8253_bus_master

Interface
REQ-001 Parameter: STROBE_CYCLES, default 2, number of clocks the read/write strobe is held low (legal 1..15).
REQ-002 Ports, one per line:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready.
- cmd_op  in  1  0 = program counter, 1 = read counter.
- cmd_counter  in  2  target counter 0..2 (3 = invalid).
- cmd_mode  in  3  8253 mode field (program only).
- cmd_bcd  in  1  BCD bit (program only).
- cmd_count  in  16  reload value (program only).
- rsp_valid  out  1  one-cycle pulse, read result valid.
- rsp_data  out  16  latched count {MSB, LSB}.
- chip_select_n  out  1  to PIT.
- read_enable_n  out  1  to PIT.
- write_enable_n  out  1  to PIT.
- address  out  2  to PIT.
- data_bus_out  out  8  write data to PIT data_bus_in.
- data_bus_in  in  8  read data from PIT data_bus_out.

Function
REQ-003 SHALL capture all cmd_* fields on acceptance; inputs are ignored until cmd_ready returns high.
REQ-004 Program op SHALL issue three writes in order: control word {cmd_counter, 2'b11, cmd_mode, cmd_bcd} to address 3; cmd_count[7:0] to address cmd_counter; cmd_count[15:8] to address cmd_counter.
REQ-005 Read op SHALL issue: latch word {cmd_counter, 6'b000000} write to address 3; read at address cmd_counter (LSB); read at address cmd_counter (MSB).
REQ-006 Each bus cycle SHALL be states SETUP (1 clk: chip_select_n=0, address/data valid, strobes high) -> STROBE (STROBE_CYCLES clks: chosen strobe low) -> HOLD (1 clk: strobe high, chip_select_n=0, address/data held).
REQ-007 FSM states: IDLE, SETUP, STROBE, HOLD; 2-bit step counter 0..2 selects the bus cycle; HOLD with step=2 -> IDLE, else -> SETUP with step+1.
REQ-008 Read data SHALL be sampled from data_bus_in on the final STROBE clock.
REQ-009 rsp_valid SHALL pulse for exactly one clock in the cycle after the final HOLD of a read op; rsp_data holds its value until the next read completes.
REQ-010 Op duration SHALL be 3*(STROBE_CYCLES+2) clocks from acceptance; cmd_ready high only in IDLE, so back-to-back acceptance is possible on the first IDLE clock.
REQ-011 cmd_counter=3 SHALL be accepted with no bus activity; program op completes in 1 clock; read op pulses rsp_valid with rsp_data=16'hFFFF the following clock.
REQ-012 Outside SETUP/STROBE/HOLD: chip_select_n, read_enable_n, write_enable_n = 1; address = 0; data_bus_out = 0.
REQ-013 read_enable_n and write_enable_n SHALL never be low simultaneously; all bus outputs SHALL be registered (glitch-free).

Reset
REQ-014 While reset is high: state IDLE, step 0, cmd_ready=1, rsp_valid=0, rsp_data=0, strobes/chip_select_n=1, address=0, data_bus_out=0.
REQ-015 Reset asserted mid-op SHALL abort immediately (asynchronously deassert strobes); no rsp_valid for the aborted op.

Structure
REQ-016 Package kf8253_bus_master_pkg SHALL hold the state enum, op encoding, control-word field positions and RW/latch constants.
REQ-017 One sub-module kf8253_bus_cycle SHALL implement a single SETUP/STROBE/HOLD cycle (start, is_read, addr, wdata -> done, rdata); the top sequences three cycles.

Verification (STROBE_CYCLES=2, bench uses PIT bus model)
REQ-018 Program counter 0, mode 3, bcd 0, count 0x1234 -> writes 0x36@3, 0x34@0, 0x12@0; cmd_ready low 12 clocks.
REQ-019 Program counter 1, mode 2, bcd 0, count 0x0100 -> writes 0x74@3, 0x00@1, 0x01@1.
REQ-020 Read counter 2, model returns 0xCD then 0xAB -> write 0x80@3, two reads @2, rsp_data=0xABCD, single rsp_valid pulse.
REQ-021 Read with cmd_counter=3 -> no chip_select_n activity, rsp_valid with 0xFFFF.
REQ-022 Reset asserted during second STROBE of a read -> strobes high same cycle, no rsp_valid, next command runs normally.
REQ-023 Back-to-back program + read with cmd_valid held high -> second accepted on first IDLE clock; no overlapping strobes.
